// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm controller.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RINGING,
        SNOOZE
    } alarm_state_t;

    localparam logic [7:0] BCD_12 = 8'h12;
    localparam logic [7:0] BCD_59 = 8'h59;
    localparam logic [7:0] BCD_00 = 8'h00;

    localparam logic       RST_ALARM_PM = 1'b0;
    localparam logic [7:0] RST_ALARM_HH = BCD_12;
    localparam logic [7:0] RST_ALARM_MM = BCD_00;

endpackage

// File: rtl/bcd_time_check.sv
// Combinational validity check for a 12-hour BCD hh:mm pair.
module bcd_time_check
    import alarm_pkg::*;
(
    input  logic [7:0] hh,
    input  logic [7:0] mm,
    output logic       valid
);

    logic hh_ok;
    logic mm_ok;

    always_comb begin
        // 01..09 or 10..12; every nibble must itself be a decimal digit
        hh_ok = ((hh[7:4] == 4'd0) && (hh[3:0] >= 4'd1) && (hh[3:0] <= 4'd9)) ||
                ((hh[7:4] == 4'd1) && (hh <= BCD_12));
        mm_ok = (mm[7:4] <= BCD_59[7:4]) && (mm[3:0] <= 4'd9);
        valid = hh_ok && mm_ok;
    end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller: stored alarm time, edge-detected minute match, ring/snooze FSM.
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int unsigned RING_SECS  = 60,
    parameter int unsigned SNOOZE_MIN = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ena,
    input  logic       pm,
    input  logic [7:0] hh,
    input  logic [7:0] mm,
    input  logic [7:0] ss,
    input  logic       arm,
    input  logic       set_we,
    input  logic       set_pm,
    input  logic [7:0] set_hh,
    input  logic [7:0] set_mm,
    input  logic       snooze,
    input  logic       dismiss,
    output logic       ring,
    output logic       snoozing,
    output logic       set_err,
    output logic       alarm_pm,
    output logic [7:0] alarm_hh,
    output logic [7:0] alarm_mm
);

    localparam int unsigned SNOOZE_SECS = SNOOZE_MIN * 60;
    localparam int unsigned RW = $clog2(RING_SECS + 1);
    localparam int unsigned SW = $clog2(SNOOZE_SECS + 1);
    localparam logic [RW-1:0] RING_LOAD = RW'(RING_SECS);
    localparam logic [SW-1:0] SNZ_LOAD  = SW'(SNOOZE_SECS);

    alarm_state_t   state;
    logic [RW-1:0]  ring_cnt;
    logic [SW-1:0]  snz_cnt;
    logic           match;
    logic           match_q;
    logic           trigger;
    logic           set_valid;

    bcd_time_check u_check (
        .hh    (set_hh),
        .mm    (set_mm),
        .valid (set_valid)
    );

    assign match   = (pm == alarm_pm) && (hh == alarm_hh) && (mm == alarm_mm) && (ss == BCD_00);
    assign trigger = match && !match_q && arm;

    always_ff @(posedge clk) begin
        if (reset) begin
            alarm_pm <= RST_ALARM_PM;
            alarm_hh <= RST_ALARM_HH;
            alarm_mm <= RST_ALARM_MM;
            set_err  <= 1'b0;
        end else begin
            set_err <= set_we && !set_valid;
            if (set_we && set_valid) begin
                alarm_pm <= set_pm;
                alarm_hh <= set_hh;
                alarm_mm <= set_mm;
            end
        end
    end

    // match_q resets high: the upstream clock also resets to 12:00:00 AM
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ring     <= 1'b0;
            snoozing <= 1'b0;
            ring_cnt <= '0;
            snz_cnt  <= '0;
            match_q  <= 1'b1;
        end else begin
            match_q <= match;
            if (!arm) begin
                state    <= IDLE;
                ring     <= 1'b0;
                snoozing <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (trigger) begin
                            state    <= RINGING;
                            ring     <= 1'b1;
                            ring_cnt <= RING_LOAD;
                        end
                    end
                    RINGING: begin
                        if (dismiss) begin
                            state <= IDLE;
                            ring  <= 1'b0;
                        end else if (snooze) begin
                            state    <= SNOOZE;
                            ring     <= 1'b0;
                            snoozing <= 1'b1;
                            snz_cnt  <= SNZ_LOAD;
                        end else if (ena) begin
                            ring_cnt <= ring_cnt - RW'(1);
                            if (ring_cnt == RW'(1)) begin
                                state <= IDLE;
                                ring  <= 1'b0;
                            end
                        end
                    end
                    SNOOZE: begin
                        if (dismiss) begin
                            state    <= IDLE;
                            snoozing <= 1'b0;
                        end else if (ena) begin
                            if (snz_cnt == SW'(1)) begin
                                state    <= RINGING;
                                ring     <= 1'b1;
                                snoozing <= 1'b0;
                                snz_cnt  <= '0;
                                ring_cnt <= RING_LOAD;
                            end else begin
                                snz_cnt <= snz_cnt - SW'(1);
                            end
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        ring     <= 1'b0;
                        snoozing <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Randomized bench for alarm_ctrl against a time-of-day reference model.
module tb_alarm_ctrl;

    localparam int RING_SECS  = 60;
    localparam int SNOOZE_MIN = 9;
    localparam int SNZ_SECS   = SNOOZE_MIN * 60;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ena = 1'b0;
    logic       pm = 1'b0;
    logic [7:0] hh = 8'h12;
    logic [7:0] mm = 8'h00;
    logic [7:0] ss = 8'h00;
    logic       arm = 1'b1;
    logic       set_we = 1'b0;
    logic       set_pm = 1'b0;
    logic [7:0] set_hh = 8'h00;
    logic [7:0] set_mm = 8'h00;
    logic       snooze = 1'b0;
    logic       dismiss = 1'b0;
    logic       ring;
    logic       snoozing;
    logic       set_err;
    logic       alarm_pm;
    logic [7:0] alarm_hh;
    logic [7:0] alarm_mm;

    alarm_ctrl #(.RING_SECS(RING_SECS), .SNOOZE_MIN(SNOOZE_MIN)) dut (
        .clk(clk), .reset(reset), .ena(ena),
        .pm(pm), .hh(hh), .mm(mm), .ss(ss),
        .arm(arm), .set_we(set_we), .set_pm(set_pm), .set_hh(set_hh), .set_mm(set_mm),
        .snooze(snooze), .dismiss(dismiss),
        .ring(ring), .snoozing(snoozing), .set_err(set_err),
        .alarm_pm(alarm_pm), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: time as seconds since midnight, alarm as minute of day.
    int tod      = 0;
    int m_alarm  = 0;
    bit m_prev   = 1'b1;
    bit m_ring   = 1'b0;
    bit m_snz    = 1'b0;
    bit m_err    = 1'b0;
    int m_left   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] bcd(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    function automatic bit bcd_ok(input logic [7:0] h, input logic [7:0] m);
        int hv, mv;
        if (h[7:4] > 4'd9 || h[3:0] > 4'd9 || m[7:4] > 4'd9 || m[3:0] > 4'd9) return 1'b0;
        hv = int'(h[7:4]) * 10 + int'(h[3:0]);
        mv = int'(m[7:4]) * 10 + int'(m[3:0]);
        return (hv >= 1) && (hv <= 12) && (mv <= 59);
    endfunction

    function automatic int to_min(input logic p, input logic [7:0] h, input logic [7:0] m);
        int hv, mv;
        hv = int'(h[7:4]) * 10 + int'(h[3:0]);
        mv = int'(m[7:4]) * 10 + int'(m[3:0]);
        return ((hv % 12) + (p ? 12 : 0)) * 60 + mv;
    endfunction

    function automatic int hour12(input int h24);
        return (h24 % 12 == 0) ? 12 : h24 % 12;
    endfunction

    task automatic drive_time();
        int h24;
        h24 = tod / 3600;
        pm  = (h24 >= 12);
        hh  = bcd(hour12(h24));
        mm  = bcd((tod / 60) % 60);
        ss  = bcd(tod % 60);
    endtask

    task automatic model_update();
        bit hit, trig;
        if (reset) begin
            m_alarm = 0; m_prev = 1'b1; m_ring = 1'b0; m_snz = 1'b0; m_err = 1'b0; m_left = 0;
        end else begin
            hit  = (tod % 60 == 0) && (tod / 60 == m_alarm);
            trig = hit && !m_prev && arm;
            m_err = set_we && !bcd_ok(set_hh, set_mm);
            if (!arm) begin
                m_ring = 1'b0; m_snz = 1'b0;
            end else if (!m_ring && !m_snz) begin
                if (trig) begin m_ring = 1'b1; m_left = RING_SECS; end
            end else if (dismiss) begin
                m_ring = 1'b0; m_snz = 1'b0;
            end else if (m_ring && snooze) begin
                m_ring = 1'b0; m_snz = 1'b1; m_left = SNZ_SECS;
            end else if (ena) begin
                m_left--;
                if (m_left == 0) begin
                    if (m_ring) m_ring = 1'b0;
                    else begin m_snz = 1'b0; m_ring = 1'b1; m_left = RING_SECS; end
                end
            end
            if (set_we && bcd_ok(set_hh, set_mm)) m_alarm = to_min(set_pm, set_hh, set_mm);
            m_prev = hit;
        end
        if (ena) tod = (tod + 1) % 86400;
    endtask

    task automatic step();
        int h24;
        @(posedge clk);
        model_update();
        @(negedge clk);
        h24 = m_alarm / 60;
        check("ring", ring, m_ring);
        check("snoozing", snoozing, m_snz);
        check("set_err", set_err, m_err);
        check("alarm_pm", alarm_pm, (h24 >= 12));
        check("alarm_hh", alarm_hh, bcd(hour12(h24)));
        check("alarm_mm", alarm_mm, bcd(m_alarm % 60));
        set_we = 1'b0; snooze = 1'b0; dismiss = 1'b0;
        drive_time();
    endtask

    task automatic set_time(input int t);
        tod = t;
        drive_time();
    endtask

    task automatic write_alarm(input logic p, input logic [7:0] h, input logic [7:0] m);
        set_we = 1'b1; set_pm = p; set_hh = h; set_mm = m;
        step();
    endtask

    task automatic wait_ring(input string tag, input int budget);
        int n;
        n = 0;
        while (ring !== 1'b1 && n < budget) begin step(); n++; end
        check(tag, ring, 1'b1);
    endtask

    task automatic count_until(input logic want, input int budget, output int n);
        n = 0;
        do begin step(); n++; end while (ring !== want && n < budget);
    endtask

    localparam int T0630 = 6 * 3600 + 30 * 60;
    localparam int T1259P = 12 * 3600 + 59 * 60;

    initial begin
        int n;
        logic [7:0] rh, rm;

        reset = 1'b1; arm = 1'b1; set_time(0);
        repeat (3) step();
        check("rst_ring", ring, 1'b0);
        check("rst_alarm_hh", alarm_hh, 8'h12);
        reset = 1'b0;
        // Sitting at 12:00:00 AM with a 12:00 AM alarm must not ring.
        repeat (5) step();
        check("supp_ring", ring, 1'b0);
        ena = 1'b1;
        repeat (5) step();

        write_alarm(1'b0, 8'h06, 8'h30);
        set_time(T0630 - 2);
        wait_ring("ring_0630", 10);
        count_until(1'b0, 100, n);
        check("ring_len", n, RING_SECS);

        set_time(T0630 - 2);
        wait_ring("ring_again", 10);
        snooze = 1'b1;
        step();
        check("snz_ring", ring, 1'b0);
        check("snz_flag", snoozing, 1'b1);
        count_until(1'b1, 700, n);
        check("snz_len", n, SNZ_SECS);
        check("snz_end_flag", snoozing, 1'b0);
        dismiss = 1'b1;
        step();

        ena = 1'b0; set_time(T0630 - 1);
        repeat (2) step();
        ena = 1'b1; step();
        ena = 1'b0;
        wait_ring("ring_hold", 5);
        snooze = 1'b1; dismiss = 1'b1;
        step();
        check("both_ring", ring, 1'b0);
        check("both_snz", snoozing, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step();
            check("no_rering", ring, 1'b0);
        end

        write_alarm(1'b0, 8'h13, 8'h30);
        check("err_hh", set_err, 1'b1);
        check("err_hh_keep", alarm_hh, 8'h06);
        step();
        check("err_one_cycle", set_err, 1'b0);
        write_alarm(1'b0, 8'h06, 8'h5A);
        check("err_mm", set_err, 1'b1);
        check("err_mm_keep", alarm_mm, 8'h30);
        write_alarm(1'b1, 8'h12, 8'h59);
        check("wr_ok_err", set_err, 1'b0);
        check("wr_ok_hh", alarm_hh, 8'h12);
        check("wr_ok_mm", alarm_mm, 8'h59);
        check("wr_ok_pm", alarm_pm, 1'b1);

        ena = 1'b1; set_time(T1259P - 1);
        wait_ring("ring_1259", 10);
        snooze = 1'b1; step();
        repeat (3) step();
        arm = 1'b0; step();
        check("disarm_snz", snoozing, 1'b0);
        check("disarm_ring", ring, 1'b0);
        arm = 1'b1;
        set_time(T1259P - 1);
        wait_ring("ring_pre_rst", 10);
        reset = 1'b1; step();
        check("midrst_ring", ring, 1'b0);
        check("midrst_hh", alarm_hh, 8'h12);
        check("midrst_mm", alarm_mm, 8'h00);
        check("midrst_pm", alarm_pm, 1'b0);
        reset = 1'b0; set_time(0);
        step();

        write_alarm(1'b0, 8'h07, 8'h05);
        for (int i = 0; i < 6000; i++) begin
            ena     = ($urandom_range(1, 0) == 1);
            snooze  = ($urandom_range(29, 0) == 0);
            dismiss = ($urandom_range(59, 0) == 0);
            arm     = ($urandom_range(199, 0) != 0);
            reset   = ($urandom_range(1999, 0) == 0);
            if ($urandom_range(99, 0) == 0) begin
                if ($urandom_range(1, 0) == 1) begin
                    rh = 8'($urandom); rm = 8'($urandom);
                end else begin
                    rh = bcd($urandom_range(12, 1)); rm = bcd($urandom_range(59, 0));
                end
                set_we = 1'b1; set_pm = 1'($urandom); set_hh = rh; set_mm = rm;
            end
            if ($urandom_range(149, 0) == 0)
                set_time((m_alarm * 60 - $urandom_range(3, 0) + 86400) % 86400);
            step();
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
